// File: rtl/ysyx_25070198_pkg.sv
// Shared definitions for the ysyx_25070198 core: the memory-access state encoding,
// access-size codes and bus timeout default. The ifu uses the same package.
package ysyx_25070198_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 256;

    // Words need addr[1:0]==0, halves need addr[0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            SIZE_WORD: mis = (addr_lo != 2'b00);
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25070198_lsu_align.sv
// Load data alignment: selects the addressed byte/half of the captured bus word
// and sign- or zero-extends it to 32 bits.
module ysyx_25070198_lsu_align
    import ysyx_25070198_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ldata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to access size.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        ldata  = rdata;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: ldata = {{24{is_signed & byte_s[7]}}, byte_s};
            SIZE_HALF: ldata = {{16{is_signed & half_s[15]}}, half_s};
            default:   ldata = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_25070198_lsu.sv
// Load/store unit: turns a held exu load/store request into a single bus
// transaction, with misalignment and response-timeout error completion.
module ysyx_25070198_lsu
    import ysyx_25070198_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_mask,
    input  logic [1:0]  io_lsu_size,
    input  logic        load_signed,
    output logic        io_lsu_respValid,
    output logic [31:0] mem_rdata,
    output logic [31:0] lsu_ldata,
    output logic        lsu_err,
    output logic        lsu_busy,
    output logic        lsu_bus_reqValid,
    output logic [31:0] lsu_bus_addr,
    output logic        lsu_bus_wen,
    output logic [31:0] lsu_bus_wdata,
    output logic [3:0]  lsu_bus_wmask,
    output logic [1:0]  lsu_bus_size,
    input  logic        lsu_bus_respValid,
    input  logic [31:0] lsu_bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r, wdata_r, rdata_r;
    logic [3:0]       mask_r;
    logic [1:0]       size_r;
    logic             signed_r, wen_r, err_r;
    logic             req_s, mis_s, bus_active_s, timeout_s;

    assign req_s     = mem_ren | mem_wen;
    assign mis_s     = is_misaligned(mem_addr[1:0], io_lsu_size);
    assign timeout_s = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; HOLD waits for the exu to drop its request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = mis_s ? ST_DONE : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (lsu_bus_respValid || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, captured read data and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= '0;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            mask_r   <= 4'h0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            wen_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_r   <= mem_addr;
                        wdata_r  <= mem_wdata;
                        mask_r   <= mem_mask;
                        size_r   <= io_lsu_size;
                        signed_r <= load_signed;
                        wen_r    <= mem_wen;
                        err_r    <= mis_s;
                    end else begin
                        err_r    <= err_r;
                    end
                end
                ST_REQ: cnt_r <= '0;
                ST_WAIT: begin
                    if (lsu_bus_respValid) begin
                        rdata_r <= wen_r ? rdata_r : lsu_bus_rdata;
                        err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rdata_r <= 32'h0000_0000;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Bus fields are only driven while a transaction is outstanding.
    assign bus_active_s     = (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign lsu_bus_reqValid = (state_r == ST_REQ);
    assign lsu_bus_addr     = bus_active_s ? addr_r  : 32'h0000_0000;
    assign lsu_bus_wen      = bus_active_s & wen_r;
    assign lsu_bus_wdata    = bus_active_s ? wdata_r : 32'h0000_0000;
    assign lsu_bus_wmask    = bus_active_s ? mask_r  : 4'h0;
    assign lsu_bus_size     = bus_active_s ? size_r  : 2'b00;

    assign io_lsu_respValid = (state_r == ST_DONE);
    assign lsu_busy         = (state_r != ST_IDLE);
    assign lsu_err          = err_r;
    assign mem_rdata        = rdata_r;

    ysyx_25070198_lsu_align u_align (
        .rdata     (rdata_r),
        .addr_lo   (addr_r[1:0]),
        .size      (size_r),
        .is_signed (signed_r),
        .ldata     (lsu_ldata)
    );

endmodule

// File: tb/tb_ysyx_25070198_lsu.sv
// Scoreboard bench for the lsu: a driver issues directed and random accesses and
// queues the expected completion, a bus responder answers requests, a monitor checks.
module tb_ysyx_25070198_lsu;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ren = 1'b0, mem_wen = 1'b0, load_signed = 1'b0;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_mask = 4'h0;
    logic [1:0]  io_lsu_size = 2'b00;
    logic        io_lsu_respValid, lsu_err, lsu_busy;
    logic [31:0] mem_rdata, lsu_ldata;
    logic        lsu_bus_reqValid, lsu_bus_wen;
    logic [31:0] lsu_bus_addr, lsu_bus_wdata;
    logic [3:0]  lsu_bus_wmask;
    logic [1:0]  lsu_bus_size;
    logic        lsu_bus_respValid = 1'b0;
    logic [31:0] lsu_bus_rdata = 32'h0;

    ysyx_25070198_lsu #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .io_lsu_size(io_lsu_size),
        .load_signed(load_signed), .io_lsu_respValid(io_lsu_respValid),
        .mem_rdata(mem_rdata), .lsu_ldata(lsu_ldata), .lsu_err(lsu_err),
        .lsu_busy(lsu_busy), .lsu_bus_reqValid(lsu_bus_reqValid),
        .lsu_bus_addr(lsu_bus_addr), .lsu_bus_wen(lsu_bus_wen),
        .lsu_bus_wdata(lsu_bus_wdata), .lsu_bus_wmask(lsu_bus_wmask),
        .lsu_bus_size(lsu_bus_size), .lsu_bus_respValid(lsu_bus_respValid),
        .lsu_bus_rdata(lsu_bus_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ren, wen, sgn;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  mask;
        logic [1:0]  size;
        int          delay, hold;
    } txn_t;

    typedef struct {
        logic [31:0] ldata, rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0, failures = 0, cyc = 0;
    int          req_count = 0, rv_seen = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = 32'h0, model_rdata = 32'h0;
    logic        rsp_busy = 1'b0;
    txn_t        cur;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pick the addressed lane from the held word and extend it.
    function automatic logic [31:0] ref_ldata(input logic [31:0] rd, input logic [31:0] addr,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Bus responder: checks request fields and answers after rsp_delay WAIT cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (lsu_bus_reqValid === 1'b1) begin
                req_count++;
                check("bus_addr", lsu_bus_addr, cur.addr);
                check("bus_wen", {31'b0, lsu_bus_wen}, {31'b0, cur.wen});
                check("bus_size", {30'b0, lsu_bus_size}, {30'b0, cur.size});
                if (cur.wen) begin
                    check("bus_wmask", {28'b0, lsu_bus_wmask}, {28'b0, cur.mask});
                    check("bus_wdata", lsu_bus_wdata, cur.wdata);
                end
                rsp_busy = 1'b1;
                repeat (rsp_delay + 1) @(negedge clock);
                lsu_bus_respValid = 1'b1;
                lsu_bus_rdata     = rsp_data;
                @(negedge clock);
                lsu_bus_respValid = 1'b0;
                lsu_bus_rdata     = $urandom;
                rsp_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each completion; bus idles at zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && lsu_busy === 1'b0) begin
                check("idle_bus", {lsu_bus_reqValid, lsu_bus_wen, lsu_bus_wmask, lsu_bus_size} |
                      lsu_bus_addr | lsu_bus_wdata, 32'h0);
            end
            if (io_lsu_respValid === 1'b1) begin
                rv_seen++;
                if (sb_q.size() == 0) begin
                    check("unexpected_respValid", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("lsu_err", {31'b0, lsu_err}, {31'b0, e.err});
                    check("mem_rdata", mem_rdata, e.rdata);
                    check("lsu_ldata", lsu_ldata, e.ldata);
                end
            end
        end
    end

    task automatic run_txn(input txn_t t);
        exp_t e;
        logic mis, tout;
        int   n;
        mis  = (t.size == 2'd2 && t.addr % 4 != 0) || (t.size == 2'd1 && t.addr % 2 != 0);
        t.wen = t.wen;
        tout = !mis && (t.delay >= TO);
        if (tout) model_rdata = 32'h0;
        else if (!mis && !t.wen) model_rdata = t.rdata;
        e.rdata = model_rdata;
        e.err   = mis || tout;
        e.ldata = ref_ldata(model_rdata, t.addr, t.size, t.sgn);
        e.cyc   = mis ? cyc + 1 : (tout ? cyc + 2 + TO : cyc + 3 + t.delay);
        sb_q.push_back(e);
        cur = t; req_count = 0; rsp_delay = t.delay; rsp_data = t.rdata;
        mem_ren = t.ren; mem_wen = t.wen; mem_addr = t.addr; mem_wdata = t.wdata;
        mem_mask = t.mask; io_lsu_size = t.size; load_signed = t.sgn;
        n = 0;
        do begin @(negedge clock); n++; end while (io_lsu_respValid !== 1'b1 && n < 40);
        if (n >= 40) check("respValid_timeout", 32'h0, 32'h1);
        repeat (t.hold) @(negedge clock);
        mem_ren = 1'b0; mem_wen = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while ((lsu_busy !== 1'b0 || rsp_busy) && n < 60);
        if (n >= 60) check("idle_timeout", 32'h0, 32'h1);
        check("reqValid_count", req_count, mis ? 32'd0 : 32'd1);
    endtask

    function automatic txn_t mk(input logic ren, wen, sgn, input logic [31:0] addr, wdata,
                                rdata, input logic [3:0] mask, input logic [1:0] size,
                                input int delay, hold);
        txn_t t;
        t.ren = ren; t.wen = wen; t.sgn = sgn; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.mask = mask; t.size = size; t.delay = delay; t.hold = hold;
        return t;
    endfunction

    initial begin
        txn_t t;
        int   n;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'b0, lsu_busy}, 32'h0);
        check("rst_respValid", {31'b0, io_lsu_respValid}, 32'h0);
        check("rst_err", {31'b0, lsu_err}, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_ldata", lsu_ldata, 32'h0);

        run_txn(mk(1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 32'hDEADBEEF, 4'h0, 2'd2, 2, 0));
        run_txn(mk(1'b1, 1'b0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF1234, 4'h0, 2'd0, 1, 1));
        run_txn(mk(1'b1, 1'b0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF1234, 4'h0, 2'd0, 0, 0));
        run_txn(mk(1'b0, 1'b1, 1'b0, 32'h8000_0002, 32'h00AB0000, 32'h11223344, 4'b0100, 2'd0, 1, 4));
        run_txn(mk(1'b1, 1'b0, 1'b0, 32'h8000_0002, 32'h0, 32'h55555555, 4'h0, 2'd2, 0, 0));
        run_txn(mk(1'b1, 1'b0, 1'b1, 32'h8000_0006, 32'h0, 32'h9234ABCD, 4'h0, 2'd1, TO - 1, 0));
        run_txn(mk(1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 32'h12345678, 4'h0, 2'd2, TO + 6, 2));
        run_txn(mk(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'hF, 2'd2, 0, 1));

        for (int i = 0; i < 40; i++) begin
            t.wen   = 1'($urandom % 2);
            t.ren   = !t.wen || ($urandom % 4 == 0);
            t.sgn   = 1'($urandom % 2);
            t.size  = 2'($urandom_range(0, 2));
            t.addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.mask  = 4'($urandom);
            t.delay = $urandom_range(0, TO + 4);
            t.hold  = $urandom_range(0, 4);
            run_txn(t);
        end

        // Reset while waiting for the bus; the late response must be ignored.
        cur = mk(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'hCAFEF00D, 4'h0, 2'd2, 4, 0);
        rsp_delay = 4; rsp_data = 32'hCAFEF00D;
        mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = cur.addr; io_lsu_size = 2'd2; load_signed = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (lsu_bus_reqValid !== 1'b1 && n < 10);
        if (n >= 10) check("rst_txn_reqValid", 32'h0, 32'h1);
        @(negedge clock);
        reset = 1'b1; mem_ren = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rv_seen = 0;
        repeat (10) @(negedge clock);
        check("midrst_respValid_count", rv_seen, 32'h0);
        check("midrst_busy", {31'b0, lsu_busy}, 32'h0);
        check("midrst_mem_rdata", mem_rdata, 32'h0);
        check("midrst_ldata", lsu_ldata, 32'h0);
        check("midrst_err", {31'b0, lsu_err}, 32'h0);
        check("scoreboard_empty", sb_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25070198_lsu.md
YSYX_25070198_LSU -- requirements
Module: ysyx_25070198_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the number of WAIT cycles without a bus response before an error completion.
REQ-002 SHALL have clock  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have mem_ren  in  1  load request from the exu, held until completion.
REQ-005 SHALL have mem_wen  in  1  store request from the exu, held while the instruction is valid.
REQ-006 SHALL have mem_addr  in  32  byte address of the access.
REQ-007 SHALL have mem_wdata  in  32  store data, already lane-shifted.
REQ-008 SHALL have mem_mask  in  4  store byte-enable.
REQ-009 SHALL have io_lsu_size  in  2  access size: 00 byte, 01 half, 10 word.
REQ-010 SHALL have load_signed  in  1  1 means sign-extend load data, 0 means zero-extend.
REQ-011 SHALL have io_lsu_respValid  out  1  completion pulse to the exu and rf.
REQ-012 SHALL have mem_rdata  out  32  raw captured bus word.
REQ-013 SHALL have lsu_ldata  out  32  aligned and extended load result.
REQ-014 SHALL have lsu_err  out  1  completion was misaligned or timed out.
REQ-015 SHALL have lsu_busy  out  1  FSM not in IDLE.
REQ-016 SHALL have lsu_bus_reqValid  out  1  bus request strobe.
REQ-017 SHALL have lsu_bus_addr  out  32  bus address.
REQ-018 SHALL have lsu_bus_wen  out  1  1 means write, 0 means read.
REQ-019 SHALL have lsu_bus_wdata  out  32  bus write data.
REQ-020 SHALL have lsu_bus_wmask  out  4  bus byte-enable.
REQ-021 SHALL have lsu_bus_size  out  2  bus access size.
REQ-022 SHALL have lsu_bus_respValid  in  1  bus response strobe.
REQ-023 SHALL have lsu_bus_rdata  in  32  bus read data, valid with lsu_bus_respValid.

Function
REQ-024 SHALL implement states IDLE, REQ, WAIT, DONE and HOLD.
REQ-025 In IDLE with (mem_ren|mem_wen)=1, the FSM SHALL latch addr, wdata, mask, size, signed and wen (wen=mem_wen); mem_wen SHALL win if both inputs are high.
REQ-026 A misaligned access SHALL go from IDLE directly to DONE with err=1 and no bus request; misaligned means size 10 with addr[1:0]!=0, or size 01 with addr[0]!=0.
REQ-027 An aligned access SHALL go from IDLE to REQ.
REQ-028 In REQ, lsu_bus_reqValid SHALL be 1 for exactly one cycle with latched fields on the bus outputs, then the FSM SHALL enter WAIT.
REQ-029 lsu_bus_* fields other than reqValid SHALL hold their latched values in REQ and WAIT, and SHALL be 0 in IDLE.
REQ-030 In WAIT, lsu_bus_respValid=1 SHALL capture lsu_bus_rdata into mem_rdata (reads only; stores leave mem_rdata unchanged), clear err, and go to DONE.
REQ-031 The WAIT counter SHALL reset to 0 on entry and increment each cycle without a response.
REQ-032 When the WAIT counter reaches TIMEOUT-1 with no response, the FSM SHALL go to DONE with err=1 and mem_rdata=0.
REQ-033 A lsu_bus_respValid outside WAIT SHALL be ignored.
REQ-034 In DONE, io_lsu_respValid SHALL be 1 for exactly one cycle and the FSM SHALL then go to HOLD.
REQ-035 The FSM SHALL leave HOLD for IDLE only in a cycle where mem_ren=0 and mem_wen=0, so that a held request is never re-issued.
REQ-036 lsu_ldata SHALL be combinational from mem_rdata and the latched addr[1:0], size and signed.
REQ-037 For size 00, lsu_ldata SHALL be byte addr[1:0], extended.
REQ-038 For size 01, lsu_ldata SHALL be halfword addr[1], extended.
REQ-039 For size 10, lsu_ldata SHALL be the full word.
REQ-040 lsu_err SHALL be valid when io_lsu_respValid=1 and SHALL hold until the next access is latched.
REQ-041 lsu_busy SHALL be 1 in every state except IDLE.

Reset
REQ-042 Reset SHALL force state IDLE, counter 0, and mem_rdata, latched fields and lsu_err to 0.
REQ-043 Out of reset, all outputs SHALL be 0.
REQ-044 Reset asserted mid-transaction SHALL abandon the transaction with no respValid pulse; a late bus response after reset SHALL be ignored under REQ-033.

Structure
REQ-045 The state enum (lsu_state_t, 3-bit), the size encodings and the TIMEOUT default SHALL live in a shared package ysyx_25070198_pkg, which the ifu SHALL also use.
REQ-046 The load alignment and extension logic SHALL be one combinational sub-module, ysyx_25070198_lsu_align.

Verification
REQ-047 Word load: addr 0x80000004, bus responds after 3 cycles with 0xDEADBEEF -> single reqValid pulse, respValid 5 cycles after acceptance, lsu_ldata=0xDEADBEEF, err=0.
REQ-048 Signed byte load: addr 0x80000003, signed=1, rdata 0x80FF1234 -> lsu_ldata=0xFFFFFF80; with signed=0 -> 0x00000080.
REQ-049 Store: mem_wen, addr 0x80000002, size 00, mask 0100, wdata 0x00AB0000 -> bus wen=1, wmask=0100; mem_rdata unchanged; respValid once; mem_wen held 4 more cycles -> no second reqValid.
REQ-050 Misaligned word load at 0x80000002 -> no reqValid, respValid next cycle with err=1.
REQ-051 No bus response with TIMEOUT=8 -> respValid after 8 WAIT cycles, err=1, lsu_ldata=0.
REQ-052 Reset asserted during WAIT, then bus response -> outputs 0, no respValid, FSM IDLE.
